// File: rtl/rv_run_ctrl_pkg.sv
// Shared definitions for the RISC-V run controller: session state encoding
// and the default end-of-program instruction (ecall).
package rv_run_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RESET = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/rv_halt_detect.sv
// Halt detector for the run controller. Flags the fetched halt instruction
// while the core runs. With RV_RUN_CTRL_SELFLOOP_HALT_EN defined it also
// flags a PC that stays unchanged across two consecutive running cycles.
module rv_halt_detect #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] HALT_INSN = 32'h0000_0073
) (
   input  logic            clk,
   input  logic            areset,
   input  logic [XLEN-1:0] core_insn,
   input  logic [XLEN-1:0] core_pc,
   input  logic            core_run,
   output logic            halt_hit
);

`ifdef RV_RUN_CTRL_SELFLOOP_HALT_EN
   logic [XLEN-1:0] prev_pc;
   logic            prev_vld;

   // Remember last cycle's PC; only meaningful if the core ran last cycle
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         prev_pc  <= '0;
         prev_vld <= 1'b0;
      end else begin
         prev_pc  <= core_pc;
         prev_vld <= core_run;
      end
   end

   assign halt_hit = core_run &&
                     ((core_insn == HALT_INSN) || (prev_vld && (core_pc == prev_pc)));
`else
   logic unused_inputs;
   assign unused_inputs = ^{clk, areset, core_pc};

   assign halt_hit = core_run && (core_insn == HALT_INSN);
`endif

endmodule

// File: rtl/rv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: streams a program into
// instruction memory, holds the core in reset, runs it under a cycle budget
// and reports halt or timeout. Optional self-loop halt detection is enabled
// with RV_RUN_CTRL_SELFLOOP_HALT_EN.
module rv_run_ctrl
   import rv_run_ctrl_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter int              IMEM_DEPTH = 64,
   parameter int              CYCLE_W    = 16,
   parameter int              RST_CYCLES = 4,
   parameter logic [XLEN-1:0] HALT_INSN  = HALT_INSN_DEFAULT,
   localparam int             AW         = $clog2(IMEM_DEPTH)
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               start,
   input  logic [CYCLE_W-1:0] max_cycles,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [XLEN-1:0]    ld_data,
   input  logic               ld_last,
   output logic               imem_we,
   output logic [AW-1:0]      imem_waddr,
   output logic [XLEN-1:0]    imem_wdata,
   output logic               core_rst_n,
   output logic               core_run,
   input  logic [XLEN-1:0]    core_pc,
   input  logic [XLEN-1:0]    core_insn,
   output logic               busy,
   output logic               done,
   output logic               halted,
   output logic               timeout,
   output logic               overflow,
   output logic [CYCLE_W-1:0] cycles_run,
   output logic [AW:0]        words_loaded
);

   localparam int            RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic [AW:0]    DEPTH_W  = (AW+1)'(IMEM_DEPTH);

   state_t             state;
   logic [CYCLE_W-1:0] max_lat;
   logic [RCW-1:0]     rst_cnt;
   logic [CYCLE_W-1:0] cycles_next;
   logic               halt_hit;

   assign cycles_next = cycles_run + 1'b1;

   assign ld_ready   = (state == S_LOAD);
   assign busy       = (state == S_LOAD) || (state == S_RESET) || (state == S_RUN);
   assign done       = (state == S_DONE);
   assign core_run   = (state == S_RUN);
   assign core_rst_n = (state == S_RUN) || (state == S_DONE);

   rv_halt_detect #(
      .XLEN      (XLEN),
      .HALT_INSN (HALT_INSN)
   ) u_halt_detect (
      .clk       (clk),
      .areset    (areset),
      .core_insn (core_insn),
      .core_pc   (core_pc),
      .core_run  (core_run),
      .halt_hit  (halt_hit)
   );

   // Session FSM with load datapath, reset-hold counter and run counter
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state        <= S_IDLE;
         max_lat      <= '0;
         rst_cnt      <= '0;
         halted       <= 1'b0;
         timeout      <= 1'b0;
         overflow     <= 1'b0;
         cycles_run   <= '0;
         words_loaded <= '0;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state        <= S_LOAD;
                  max_lat      <= max_cycles;
                  halted       <= 1'b0;
                  timeout      <= 1'b0;
                  overflow     <= 1'b0;
                  cycles_run   <= '0;
                  words_loaded <= '0;
               end
            end
            S_LOAD: begin
               if (ld_valid) begin
                  // Words past the end of memory are still consumed so the
                  // stream can reach ld_last, but only flagged
                  if (words_loaded == DEPTH_W) begin
                     overflow <= 1'b1;
                  end else begin
                     imem_we      <= 1'b1;
                     imem_waddr   <= words_loaded[AW-1:0];
                     imem_wdata   <= ld_data;
                     words_loaded <= words_loaded + 1'b1;
                  end
                  if (ld_last) begin
                     state   <= S_RESET;
                     rst_cnt <= '0;
                  end
               end
            end
            S_RESET: begin
               if (rst_cnt == RST_LAST) begin
                  state <= S_RUN;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (cycles_run != '1) begin
                  cycles_run <= cycles_next;
               end
               // The detecting cycle itself executes, hence compare against
               // the post-increment count
               if (halt_hit) begin
                  state  <= S_DONE;
                  halted <= 1'b1;
               end else if ((max_lat != '0) && (cycles_next == max_lat)) begin
                  state   <= S_DONE;
                  timeout <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
